// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory-side controller.
//   mem_state_t       - controller FSM states
//   SRAM_ADDR_W       - external SRAM address width
//   WORD_W            - LC-3 data/address word width
//   MMIO_ADDR_DEFAULT - default address of the switch/hex I/O word
package lc3_mem_pkg;

  localparam int unsigned SRAM_ADDR_W = 20;
  localparam int unsigned WORD_W      = 16;

  localparam logic [WORD_W-1:0] MMIO_ADDR_DEFAULT = 16'hFFFF;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWrSetup,
    StWrPulse,
    StWrHold,
    StIo
  } mem_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus of quasi-static asynchronous inputs (board switches).
// Ports:
//   clk   - destination clock
//   reset - synchronous, active-high; clears both stages to 0
//   d     - asynchronous input bus
//   q     - synchronized output bus (two cycles of latency)
module sync_2ff #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/lc3_sram_ctrl.sv
// LC-3 memory-side stage: turns the control unit's active-low strobes plus MAR/MDR into
// timed asynchronous-SRAM cycles, returns read data to the MDR mux, and decodes the
// memory-mapped I/O word (switches in, hex display out).
// Optional build macro: MEM_ACCESS_CNT_EN adds rd_count_o / wr_count_o access counters.
// Ports:
//   Clk, Reset            - clock, synchronous active-high reset
//   Mem_CE/Mem_OE/Mem_WE  - active-low strobes from the control unit
//   mar_i, mdr_i          - address and write data, latched at the request edge
//   switches_i            - asynchronous board switches
//   rdata_o, rvalid_o     - captured read data and its one-cycle valid pulse
//   busy_o                - access in progress; strobes are ignored meanwhile
//   hex_o                 - hex display register
//   sram_*                - SRAM pins, all decoded from registered state only
//   rd_count_o/wr_count_o - completed access counters (MEM_ACCESS_CNT_EN only)
module lc3_sram_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int unsigned       READ_WAIT   = 1,
  parameter int unsigned       WRITE_PULSE = 2,
  parameter logic [WORD_W-1:0] MMIO_ADDR   = MMIO_ADDR_DEFAULT
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Mem_CE,
  input  logic                   Mem_OE,
  input  logic                   Mem_WE,
  input  logic [WORD_W-1:0]      mar_i,
  input  logic [WORD_W-1:0]      mdr_i,
  input  logic [WORD_W-1:0]      switches_i,
  output logic [WORD_W-1:0]      rdata_o,
  output logic                   rvalid_o,
  output logic                   busy_o,
  output logic [WORD_W-1:0]      hex_o,
  output logic [SRAM_ADDR_W-1:0] sram_addr_o,
  input  logic [WORD_W-1:0]      sram_dq_i,
  output logic [WORD_W-1:0]      sram_dq_o,
  output logic                   sram_dq_oe,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n,
  output logic                   sram_we_n,
  output logic                   sram_ub_n,
  output logic                   sram_lb_n
`ifdef MEM_ACCESS_CNT_EN
  ,
  output logic [15:0]            rd_count_o,
  output logic [15:0]            wr_count_o
`endif
);

  localparam logic [2:0] RdLoad    = 3'(READ_WAIT);
  localparam logic [2:0] PulseLoad = 3'(WRITE_PULSE - 1);

  mem_state_t        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              prev_oe_q, prev_we_q;
  logic              io_wr_q;
  logic [WORD_W-1:0] io_data_q;
  logic [WORD_W-1:0] sram_addr_q;
  logic [WORD_W-1:0] sram_dq_q;
  logic [WORD_W-1:0] rdata_q;
  logic              rvalid_q;
  logic [WORD_W-1:0] hex_q;
  logic [WORD_W-1:0] sw_sync;

  logic oe_fall, we_fall;
  logic req_wr, req_rd, req_io, start;
  logic rd_done, io_rd_done, io_wr_done;

  sync_2ff #(
    .Width(WORD_W)
  ) u_sync_sw (
    .clk  (Clk),
    .reset(Reset),
    .d    (switches_i),
    .q    (sw_sync)
  );

  always_comb begin
    oe_fall    = prev_oe_q & ~Mem_OE;
    we_fall    = prev_we_q & ~Mem_WE;
    // A write edge wins over a simultaneous read edge; the read is dropped.
    req_wr     = ~Mem_CE & we_fall;
    req_rd     = ~Mem_CE & oe_fall & ~we_fall;
    req_io     = (mar_i == MMIO_ADDR);
    start      = (state_q == StIdle) & (req_wr | req_rd);
    rd_done    = (state_q == StRd) & (cnt_q == 3'd0);
    io_rd_done = (state_q == StIo) & ~io_wr_q;
    io_wr_done = (state_q == StIo) & io_wr_q;

    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (req_io) begin
            state_d = StIo;
          end else if (req_wr) begin
            state_d = StWrSetup;
          end else begin
            state_d = StRd;
            cnt_d   = RdLoad;
          end
        end
      end
      StRd: begin
        if (cnt_q == 3'd0) state_d = StIdle;
        else               cnt_d   = cnt_q - 3'd1;
      end
      StWrSetup: begin
        state_d = StWrPulse;
        cnt_d   = PulseLoad;
      end
      StWrPulse: begin
        if (cnt_q == 3'd0) state_d = StWrHold;
        else               cnt_d   = cnt_q - 3'd1;
      end
      StWrHold: state_d = StIdle;
      StIo:     state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      prev_oe_q   <= 1'b1;
      prev_we_q   <= 1'b1;
      io_wr_q     <= 1'b0;
      io_data_q   <= '0;
      sram_addr_q <= '0;
      sram_dq_q   <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      hex_q       <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prev_oe_q <= Mem_OE;
      prev_we_q <= Mem_WE;
      if (start) begin
        // I/O accesses keep the SRAM address/data pins untouched.
        if (req_io) begin
          io_wr_q   <= req_wr;
          io_data_q <= mdr_i;
        end else begin
          sram_addr_q <= mar_i;
          if (req_wr) sram_dq_q <= mdr_i;
        end
      end
      rvalid_q <= rd_done | io_rd_done;
      if (rd_done)         rdata_q <= sram_dq_i;
      else if (io_rd_done) rdata_q <= sw_sync;
      if (io_wr_done) hex_q <= io_data_q;
    end
  end

  always_comb begin
    sram_ce_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_dq_oe = 1'b0;
    unique case (state_q)
      StRd: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
      end
      StWrSetup, StWrHold: begin
        sram_ce_n  = 1'b0;
        sram_dq_oe = 1'b1;
      end
      StWrPulse: begin
        sram_ce_n  = 1'b0;
        sram_we_n  = 1'b0;
        sram_dq_oe = 1'b1;
      end
      default: ;
    endcase
    sram_ub_n = sram_ce_n;
    sram_lb_n = sram_ce_n;
  end

  assign sram_addr_o = {{(SRAM_ADDR_W - WORD_W){1'b0}}, sram_addr_q};
  assign sram_dq_o   = sram_dq_q;
  assign rdata_o     = rdata_q;
  assign rvalid_o    = rvalid_q;
  assign hex_o       = hex_q;
  assign busy_o      = (state_q != StIdle);

`ifdef MEM_ACCESS_CNT_EN
  logic [15:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (rd_done | io_rd_done)                 rd_cnt_q <= rd_cnt_q + 16'd1;
      if ((state_q == StWrHold) | io_wr_done)   wr_cnt_q <= wr_cnt_q + 16'd1;
    end
  end

  assign rd_count_o = rd_cnt_q;
  assign wr_count_o = wr_cnt_q;
`endif

endmodule

// File: tb/tb_lc3_sram_ctrl.sv
// Self-checking bench for lc3_sram_ctrl with a behavioural asynchronous-SRAM device and a
// word-level memory/I/O expectation model.
module tb_lc3_sram_ctrl;

  localparam int unsigned RW = 1;
  localparam int unsigned WP = 2;

  logic        Clk, Reset, Mem_CE, Mem_OE, Mem_WE;
  logic [15:0] mar_i, mdr_i, switches_i;
  logic [15:0] rdata_o, hex_o, sram_dq_i, sram_dq_o;
  logic        rvalid_o, busy_o, sram_dq_oe;
  logic [19:0] sram_addr_o;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
`ifdef MEM_ACCESS_CNT_EN
  logic [15:0] rd_count_o, wr_count_o;
`endif

  int errors = 0;
  int checks = 0;

  lc3_sram_ctrl #(
    .READ_WAIT  (RW),
    .WRITE_PULSE(WP),
    .MMIO_ADDR  (16'hFFFF)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Mem_CE     (Mem_CE),
    .Mem_OE     (Mem_OE),
    .Mem_WE     (Mem_WE),
    .mar_i      (mar_i),
    .mdr_i      (mdr_i),
    .switches_i (switches_i),
    .rdata_o    (rdata_o),
    .rvalid_o   (rvalid_o),
    .busy_o     (busy_o),
    .hex_o      (hex_o),
    .sram_addr_o(sram_addr_o),
    .sram_dq_i  (sram_dq_i),
    .sram_dq_o  (sram_dq_o),
    .sram_dq_oe (sram_dq_oe),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n),
    .sram_ub_n  (sram_ub_n),
    .sram_lb_n  (sram_lb_n)
`ifdef MEM_ACCESS_CNT_EN
    ,
    .rd_count_o (rd_count_o),
    .wr_count_o (wr_count_o)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Unwritten SRAM words hold a fixed pattern; 0x3000 -> 0x1234.
  function automatic logic [15:0] init_val(input logic [15:0] a);
    return a ^ 16'h2234;
  endfunction

  // ---------------- SRAM device model + pin monitor (negedge sampling) ----------------
  logic [15:0] sram_mem [0:65535];
  bit          sram_wr  [0:65535];
  logic [15:0] dev_a;
  assign dev_a     = sram_addr_o[15:0];
  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ?
                     (sram_wr[dev_a] ? sram_mem[dev_a] : init_val(dev_a)) : 16'h0BAD;

  bit          pend = 1'b0;
  logic [15:0] pend_a, pend_d;
  int mon_oe_low = 0, mon_we_low = 0, mon_dqoe = 0, mon_busy = 0;
  int mon_ce_low = 0, mon_rv = 0, mon_pin_chg = 0;
  logic [35:0] last_pins = '0;

  always @(negedge Clk) begin
    // Write commits on the rising edge of we_n only while the chip stays selected.
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
      pend   = 1'b1;
      pend_a = dev_a;
      pend_d = sram_dq_o;
    end else if (pend && sram_we_n && !sram_ce_n) begin
      sram_mem[pend_a] = pend_d;
      sram_wr[pend_a]  = 1'b1;
      pend             = 1'b0;
    end else if (sram_ce_n) begin
      pend = 1'b0;
    end
    if (!sram_oe_n) mon_oe_low++;
    if (!sram_we_n) mon_we_low++;
    if (sram_dq_oe) mon_dqoe++;
    if (busy_o)     mon_busy++;
    if (!sram_ce_n || !sram_ub_n || !sram_lb_n) mon_ce_low++;
    if (rvalid_o)   mon_rv++;
    if ({sram_addr_o, sram_dq_o} != last_pins) mon_pin_chg++;
    last_pins = {sram_addr_o, sram_dq_o};
  end

  function automatic logic [15:0] dev_read(input logic [15:0] a);
    return sram_wr[a] ? sram_mem[a] : init_val(a);
  endfunction

  // ---------------- expectation model ----------------
  logic [15:0] exp_mem [int];
  function automatic logic [15:0] exp_read(input logic [15:0] a);
    return exp_mem.exists(int'(a)) ? exp_mem[int'(a)] : init_val(a);
  endfunction

  int acc_oe, acc_we, acc_dqoe, acc_busy, acc_ce, acc_rv, acc_chg;

  // Strobe for one cycle (cycle 0), then watch 10 cycles; rv_at = cycle of first rvalid.
  task automatic access(input bit rd, input bit wr, input logic [15:0] addr,
                        input logic [15:0] data, output int rv_at);
    int b_oe, b_we, b_dq, b_bz, b_ce, b_rv, b_ch;
    b_oe = mon_oe_low; b_we = mon_we_low; b_dq = mon_dqoe; b_bz = mon_busy;
    b_ce = mon_ce_low; b_rv = mon_rv; b_ch = mon_pin_chg;
    rv_at  = -1;
    mar_i  = addr;
    mdr_i  = data;
    Mem_CE = 1'b0;
    if (rd) Mem_OE = 1'b0;
    if (wr) Mem_WE = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge Clk); #1;
      if (c == 1) begin
        Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1;
      end
      if (rvalid_o && rv_at < 0) rv_at = c;
    end
    acc_oe = mon_oe_low - b_oe; acc_we = mon_we_low - b_we; acc_dqoe = mon_dqoe - b_dq;
    acc_busy = mon_busy - b_bz; acc_ce = mon_ce_low - b_ce; acc_rv = mon_rv - b_rv;
    acc_chg = mon_pin_chg - b_ch;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    @(posedge Clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    checks++; if (rdata_o !== 16'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0000", rdata_o); end
    checks++; if ({rvalid_o, busy_o, sram_dq_oe} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {rvalid_o, busy_o, sram_dq_oe}); end
    checks++; if (hex_o !== 16'h0) begin errors++; $display("FAIL reset_hex: got %h want 0000", hex_o); end
    checks++; if ({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n} !== 5'b11111) begin errors++; $display("FAIL reset_strobes: got %b want 11111", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}); end
    checks++; if ({sram_addr_o, sram_dq_o} !== 36'h0) begin errors++; $display("FAIL reset_addr_dq: got %h want 0", {sram_addr_o, sram_dq_o}); end
    #1 Reset = 1'b0;
    @(posedge Clk); #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b want 0", busy_o); end
  endtask

  task automatic test_read();
    int rv;
    access(1'b1, 1'b0, 16'h3000, 16'h0, rv);
    checks++; if (rv != int'(RW) + 2) begin errors++; $display("FAIL read_latency: got %0d want %0d", rv, RW + 2); end
    checks++; if (rdata_o !== 16'h1234) begin errors++; $display("FAIL read_data: got %h want 1234", rdata_o); end
    checks++; if (acc_oe != int'(RW) + 1) begin errors++; $display("FAIL read_oe_cycles: got %0d want %0d", acc_oe, RW + 1); end
    checks++; if (acc_rv != 1) begin errors++; $display("FAIL read_rvalid_count: got %0d want 1", acc_rv); end
    checks++; if (acc_busy != int'(RW) + 1 || acc_we != 0 || acc_dqoe != 0) begin errors++; $display("FAIL read_busy_we_dq: got %0d/%0d/%0d want %0d/0/0", acc_busy, acc_we, acc_dqoe, RW + 1); end
  endtask

  task automatic test_write();
    int rv;
    access(1'b0, 1'b1, 16'h3001, 16'hBEEF, rv);
    exp_mem[32'h3001] = 16'hBEEF;
    checks++; if (acc_we != int'(WP)) begin errors++; $display("FAIL write_we_cycles: got %0d want %0d", acc_we, WP); end
    checks++; if (acc_dqoe != int'(WP) + 2) begin errors++; $display("FAIL write_dqoe_cycles: got %0d want %0d", acc_dqoe, WP + 2); end
    checks++; if (acc_busy != int'(WP) + 2) begin errors++; $display("FAIL write_busy_cycles: got %0d want %0d", acc_busy, WP + 2); end
    checks++; if (dev_read(16'h3001) !== 16'hBEEF) begin errors++; $display("FAIL write_sram_content: got %h want beef", dev_read(16'h3001)); end
    checks++; if (acc_oe != 0 || acc_rv != 0) begin errors++; $display("FAIL write_no_read: got oe=%0d rv=%0d want 0/0", acc_oe, acc_rv); end
    checks++; if (rdata_o !== 16'h1234) begin errors++; $display("FAIL write_rdata_hold: got %h want 1234", rdata_o); end
  endtask

  task automatic test_mmio();
    int rv;
    switches_i = 16'h00A5;
    repeat (3) @(posedge Clk);
    #1;
    access(1'b1, 1'b0, 16'hFFFF, 16'h0, rv);
    checks++; if (rdata_o !== 16'h00A5) begin errors++; $display("FAIL mmio_read_data: got %h want 00a5", rdata_o); end
    checks++; if (rv != 2) begin errors++; $display("FAIL mmio_read_latency: got %0d want 2", rv); end
    checks++; if (acc_ce != 0 || acc_oe != 0 || acc_dqoe != 0 || acc_chg != 0) begin errors++; $display("FAIL mmio_read_pins: got ce=%0d oe=%0d dq=%0d chg=%0d want 0", acc_ce, acc_oe, acc_dqoe, acc_chg); end
    checks++; if (acc_busy != 1) begin errors++; $display("FAIL mmio_busy: got %0d want 1", acc_busy); end
    access(1'b0, 1'b1, 16'hFFFF, 16'h0042, rv);
    checks++; if (hex_o !== 16'h0042) begin errors++; $display("FAIL mmio_write_hex: got %h want 0042", hex_o); end
    checks++; if (acc_ce != 0 || acc_we != 0 || acc_chg != 0 || rv != -1) begin errors++; $display("FAIL mmio_write_pins: got ce=%0d we=%0d chg=%0d rv=%0d", acc_ce, acc_we, acc_chg, rv); end
  endtask

  task automatic test_busy();
    int b_oe, b_bz, rv_seen, rv;
    b_oe = mon_oe_low; b_bz = mon_busy; rv_seen = 0;
    mar_i = 16'h3002; mdr_i = 16'h5A5A; Mem_CE = 1'b0; Mem_WE = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge Clk); #1;
      if (c == 1) begin Mem_CE = 1'b1; Mem_WE = 1'b1; end
      // Read strobe falls mid-write and stays low past the return to idle.
      if (c == 2) begin Mem_CE = 1'b0; Mem_OE = 1'b0; mar_i = 16'h3000; end
      if (c == 8) begin Mem_CE = 1'b1; Mem_OE = 1'b1; end
      if (rvalid_o) rv_seen++;
    end
    exp_mem[32'h3002] = 16'h5A5A;
    checks++; if (rv_seen != 0 || mon_oe_low != b_oe) begin errors++; $display("FAIL busy_strobe_ignored: got rv=%0d oe=%0d want 0/0", rv_seen, mon_oe_low - b_oe); end
    checks++; if (mon_busy - b_bz != int'(WP) + 2) begin errors++; $display("FAIL busy_write_len: got %0d want %0d", mon_busy - b_bz, WP + 2); end
    checks++; if (dev_read(16'h3002) !== 16'h5A5A) begin errors++; $display("FAIL busy_write_data: got %h want 5a5a", dev_read(16'h3002)); end
    access(1'b1, 1'b1, 16'h3003, 16'h7E57, rv);
    exp_mem[32'h3003] = 16'h7E57;
    checks++; if (rv != -1 || acc_oe != 0) begin errors++; $display("FAIL dual_strobe_no_read: got rv=%0d oe=%0d want -1/0", rv, acc_oe); end
    checks++; if (acc_we != int'(WP) || dev_read(16'h3003) !== 16'h7E57) begin errors++; $display("FAIL dual_strobe_write: got we=%0d data=%h want %0d/7e57", acc_we, dev_read(16'h3003), WP); end
  endtask

  task automatic test_reset_mid_access();
    int rv, b_rv;
    mar_i = 16'h3004; mdr_i = 16'hCAFE; Mem_CE = 1'b0; Mem_WE = 1'b0;
    @(posedge Clk); #1;
    Mem_CE = 1'b1; Mem_WE = 1'b1;
    @(posedge Clk); #1;
    checks++; if (sram_we_n !== 1'b0) begin errors++; $display("FAIL pulse_first_cycle: got we_n=%b want 0", sram_we_n); end
    Reset = 1'b1;
    @(posedge Clk); #1;
    checks++; if ({sram_we_n, sram_dq_oe, busy_o} !== 3'b100) begin errors++; $display("FAIL reset_mid_write_pins: got %b want 100", {sram_we_n, sram_dq_oe, busy_o}); end
    checks++; if (hex_o !== 16'h0) begin errors++; $display("FAIL reset_mid_write_hex: got %h want 0000", hex_o); end
    Reset = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    access(1'b1, 1'b0, 16'h3004, 16'h0, rv);
    checks++; if (rdata_o !== exp_read(16'h3004) || rv != int'(RW) + 2) begin errors++; $display("FAIL reset_write_aborted: got %h rv=%0d want %h rv=%0d", rdata_o, rv, exp_read(16'h3004), RW + 2); end
    b_rv = mon_rv;
    mar_i = 16'h3000; Mem_CE = 1'b0; Mem_OE = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b1; Mem_CE = 1'b1; Mem_OE = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    checks++; if (busy_o !== 1'b0 || sram_oe_n !== 1'b1) begin errors++; $display("FAIL reset_mid_read_pins: got busy=%b oe_n=%b want 0/1", busy_o, sram_oe_n); end
    repeat (4) @(posedge Clk);
    #1;
    checks++; if (mon_rv != b_rv || rdata_o !== 16'h0) begin errors++; $display("FAIL reset_mid_read_norvalid: got rv=%0d rdata=%h want 0/0000", mon_rv - b_rv, rdata_o); end
  endtask

  task automatic test_random();
    int rv, kind, want_rv;
    logic [15:0] a, d, exp_rdata, exp_hex, exp_sw;
    do_reset();
    exp_rdata = 16'h0; exp_hex = 16'h0; exp_sw = 16'h0;
    for (int i = 0; i < 32; i++) begin
      kind = int'($urandom_range(0, 3));
      a    = (kind < 2) ? 16'h4000 + 16'($urandom_range(0, 7)) : 16'hFFFF;
      d    = 16'($urandom);
      if (kind == 2) begin
        switches_i = 16'($urandom);
        exp_sw     = switches_i;
        repeat (3) @(posedge Clk);
        #1;
      end
      access(kind == 0 || kind == 2, kind == 1 || kind == 3, a, d, rv);
      want_rv = -1;
      case (kind)
        0: begin exp_rdata = exp_read(a); want_rv = int'(RW) + 2; end
        1: exp_mem[int'(a)] = d;
        2: begin exp_rdata = exp_sw; want_rv = 2; end
        default: exp_hex = d;
      endcase
      checks++; if (rv != want_rv || rdata_o !== exp_rdata || hex_o !== exp_hex) begin errors++; $display("FAIL random_op%0d kind%0d: got rv=%0d rdata=%h hex=%h want rv=%0d rdata=%h hex=%h", i, kind, rv, rdata_o, hex_o, want_rv, exp_rdata, exp_hex); end
    end
    for (int j = 0; j < 8; j++) begin
      a = 16'h4000 + 16'(j);
      checks++; if (dev_read(a) !== exp_read(a)) begin errors++; $display("FAIL random_sram_%h: got %h want %h", a, dev_read(a), exp_read(a)); end
    end
  endtask

`ifdef MEM_ACCESS_CNT_EN
  task automatic test_counters();
    int rv;
    do_reset();
    checks++; if (rd_count_o !== 16'h0 || wr_count_o !== 16'h0) begin errors++; $display("FAIL cnt_reset: got %h/%h want 0/0", rd_count_o, wr_count_o); end
    access(1'b1, 1'b0, 16'h3000, 16'h0, rv);
    access(1'b0, 1'b1, 16'h3006, 16'h1111, rv);
    access(1'b1, 1'b0, 16'h3001, 16'h0, rv);
    access(1'b0, 1'b1, 16'hFFFF, 16'h0007, rv);
    access(1'b1, 1'b0, 16'hFFFF, 16'h0, rv);
    checks++; if (rd_count_o !== 16'd3) begin errors++; $display("FAIL cnt_reads: got %0d want 3", rd_count_o); end
    checks++; if (wr_count_o !== 16'd2) begin errors++; $display("FAIL cnt_writes: got %0d want 2", wr_count_o); end
  endtask
`endif

  initial begin
    Reset = 1'b1; Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1;
    mar_i = '0; mdr_i = '0; switches_i = '0;
    test_reset();
    test_read();
    test_write();
    test_mmio();
    test_busy();
    test_reset_mid_access();
    test_random();
`ifdef MEM_ACCESS_CNT_EN
    test_counters();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
